// File: rtl/axi_lite_resp_mem_if.sv
// AXI4-Lite bus bundle between one manager and the axi_lite_resp_mem responder.
interface axi_lite_resp_mem_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_resp_mem.sv
// AXI4-Lite responder backed by a word-addressed memory; one transaction in flight,
// read/write alternate when both address channels request in the same cycle.
module axi_lite_resp_mem #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 256
) (
    input  logic               aclk,
    input  logic               areset,
    axi_lite_resp_mem_if.slave bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned WIDX_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned MEM_AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_rd_q, last_rd_d;
    logic [WIDX_WIDTH-1:0]  widx_q, widx_d;

    logic                   awready_q, awready_d;
    logic                   wready_q,  wready_d;
    logic                   arready_q, arready_d;
    logic                   bvalid_q,  bvalid_d;
    logic                   rvalid_q,  rvalid_d;
    logic [1:0]             bresp_q,   bresp_d;
    logic [1:0]             rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0]  rdata_q,   rdata_d;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_WORDS];
    logic                   mem_we;

    logic [WIDX_WIDTH-1:0]  ar_idx;
    logic [WIDX_WIDTH-1:0]  aw_idx;
    logic                   ar_in_range;
    logic                   w_in_range;
    logic                   unused_addr_lsbs;

    // Byte offset bits never affect the word selected.
    assign ar_idx           = bus.araddr[ADDR_WIDTH-1:2];
    assign aw_idx           = bus.awaddr[ADDR_WIDTH-1:2];
    assign ar_in_range      = 32'(ar_idx) < MEM_WORDS;
    assign w_in_range       = 32'(widx_q) < MEM_WORDS;
    assign unused_addr_lsbs = ^{bus.araddr[1:0], bus.awaddr[1:0]};

    // State and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b0;
            widx_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            widx_q    <= widx_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic; a simultaneous request goes to the direction not served last.
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        widx_d    = widx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.arvalid && (!bus.awvalid || !last_rd_q)) begin
                    state_d = S_RADDR;
                end else if (bus.awvalid) begin
                    state_d = S_WADDR;
                end
            end
            S_RADDR: state_d = S_RDATA;
            S_RDATA: begin
                if (bus.rready) begin
                    state_d   = S_IDLE;
                    last_rd_d = 1'b1;
                end
            end
            S_WADDR: begin
                widx_d  = aw_idx;
                state_d = S_WDATA;
            end
            S_WDATA: begin
                if (bus.wvalid) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bus.bready) begin
                    state_d   = S_IDLE;
                    last_rd_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake flags decode the upcoming state so they register cleanly.
    always_comb begin
        awready_d = (state_d == S_WADDR);
        wready_d  = (state_d == S_WDATA);
        arready_d = (state_d == S_RADDR);
        bvalid_d  = (state_d == S_WRESP);
        rvalid_d  = (state_d == S_RDATA);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        if (state_q == S_RADDR) begin
            if (ar_in_range) begin
                rdata_d = mem_q[ar_idx[MEM_AW-1:0]];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
        if ((state_q == S_WDATA) && bus.wvalid) begin
            mem_we  = w_in_range;
            bresp_d = w_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Storage has no reset; only strobed lanes of an in-range word change.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (bus.wstrb[b]) begin
                    mem_q[widx_q[MEM_AW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.arready = arready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_resp_mem.sv
// Self-checking bench for axi_lite_resp_mem: directed scenarios plus random traffic
// compared against a word-array model of the memory.
module tb_axi_lite_resp_mem;
    localparam int unsigned AW      = 12;
    localparam int unsigned DW      = 32;
    localparam int unsigned WORDS   = 256;
    localparam int          TIMEOUT = 50;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_lite_resp_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_resp_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(WORDS)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ref_mem [WORDS];

    function automatic logic [1:0] exp_resp(input logic [11:0] addr);
        return ((int'(addr) / 4) >= int'(WORDS)) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] addr);
        int w;
        w = int'(addr) / 4;
        if (w >= int'(WORDS)) return 32'h0;
        return ref_mem[w];
    endfunction

    function automatic void model_write(input logic [11:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int w;
        w = int'(addr) / 4;
        if (w >= int'(WORDS)) return;
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic logic sig_val(input int sel);
        case (sel)
            0:       return bus.awready;
            1:       return bus.wready;
            2:       return bus.bvalid;
            3:       return bus.arready;
            default: return bus.rvalid;
        endcase
    endfunction

    task automatic idle_bus();
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    // Counts sampled cycles until the selected ready/valid is seen high; an expired bound fails.
    task automatic wait_sig(input int sel, output int cnt);
        cnt = 0;
        @(negedge aclk);
        while (sig_val(sel) !== 1'b1 && cnt < TIMEOUT) begin
            cnt++;
            @(negedge aclk);
        end
        n_checks++;
        if (cnt >= TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_sel%0d: waited %0d cycles, required < %0d", sel, cnt, TIMEOUT);
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int aw_wait, output int b_wait);
        int w_wait;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        wait_sig(0, aw_wait);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        wait_sig(1, w_wait);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0; bus.bready = 1'b1;
        wait_sig(2, b_wait);
        resp = bus.bresp;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int ar_wait, output int r_wait);
        bus.araddr = addr; bus.arvalid = 1'b1;
        wait_sig(3, ar_wait);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        wait_sig(4, r_wait);
        data = bus.rdata; resp = bus.rresp;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        n_checks++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h, required all zero",
                     bus.bresp, bus.rresp, bus.rdata);
        end
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_checks++;
            if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: got %b, required 00000",
                         {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_fill();
        logic [1:0] resp; logic [31:0] d; int aw_w, b_w;
        for (int w = 0; w < int'(WORDS); w++) begin
            d = $urandom;
            axi_write(12'(w * 4), d, 4'hF, resp, aw_w, b_w);
            model_write(12'(w * 4), d, 4'hF);
            n_checks++;
            if (resp !== 2'b00) begin
                n_fail++;
                $display("FAIL fill_bresp word %0d: got %b, required 00", w, resp);
            end
        end
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic [31:0] d; int aw_w, b_w, ar_w, r_w;
        axi_write(12'h012, 32'hDEADBEEF, 4'hF, resp, aw_w, b_w);
        model_write(12'h012, 32'hDEADBEEF, 4'hF);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b, required 00", resp); end
        n_checks++;
        if (b_w !== 0) begin n_fail++; $display("FAIL bvalid_latency: got %0d extra cycles, required 0", b_w); end
        axi_read(12'h010, d, resp, ar_w, r_w);
        n_checks++;
        if (d !== exp_read(12'h010)) begin
            n_fail++; $display("FAIL rd_data: got %h, required %h", d, exp_read(12'h010));
        end
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $display("FAIL rd_rresp: got %b, required 00", resp); end
        n_checks++;
        if (ar_w !== 1) begin n_fail++; $display("FAIL arready_latency: got N+%0d, required N+1", ar_w); end
        n_checks++;
        if (ar_w + 1 + r_w !== 2) begin
            n_fail++; $display("FAIL rvalid_latency: got N+%0d, required N+2", ar_w + 1 + r_w);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; int aw_w, b_w, ar_w, r_w;
        axi_write(12'h020, 32'hFFFFFFFF, 4'hF, resp, aw_w, b_w);
        model_write(12'h020, 32'hFFFFFFFF, 4'hF);
        axi_write(12'h020, 32'h00000000, 4'h5, resp, aw_w, b_w);
        model_write(12'h020, 32'h00000000, 4'h5);
        axi_read(12'h020, d, resp, ar_w, r_w);
        n_checks++;
        if (d !== exp_read(12'h020)) begin
            n_fail++; $display("FAIL strobe_merge: got %h, required %h", d, exp_read(12'h020));
        end
        axi_write(12'h020, 32'h12345678, 4'h0, resp, aw_w, b_w);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $display("FAIL strobe0_bresp: got %b, required 00", resp); end
        axi_read(12'h023, d, resp, ar_w, r_w);
        n_checks++;
        if (d !== exp_read(12'h020)) begin
            n_fail++; $display("FAIL strobe0_noop: got %h, required %h", d, exp_read(12'h020));
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d; int aw_w, b_w, ar_w, r_w;
        axi_write(12'h400, $urandom, 4'hF, resp, aw_w, b_w);
        n_checks++;
        if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b, required 10", resp); end
        axi_read(12'h7FC, d, resp, ar_w, r_w);
        n_checks++;
        if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_rresp: got %b, required 10", resp); end
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h, required 00000000", d); end
        axi_read(12'h000, d, resp, ar_w, r_w);
        n_checks++;
        if (d !== exp_read(12'h000)) begin
            n_fail++; $display("FAIL oor_word0_kept: got %h, required %h", d, exp_read(12'h000));
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] d, rd; int aw_w, b_w, ar_w, r_w;
        d = $urandom;
        bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            n_checks++;
            if ({bus.wready, bus.bvalid, bus.awready} !== 3'b000) begin
                n_fail++;
                $display("FAIL early_w_held: got wready/bvalid/awready=%b, required 000",
                         {bus.wready, bus.bvalid, bus.awready});
            end
        end
        @(posedge aclk); #1;
        axi_write(12'h044, d, 4'hF, resp, aw_w, b_w);
        model_write(12'h044, d, 4'hF);
        axi_read(12'h044, rd, resp, ar_w, r_w);
        n_checks++;
        if (rd !== exp_read(12'h044)) begin
            n_fail++; $display("FAIL early_w_data: got %h, required %h", rd, exp_read(12'h044));
        end
    endtask

    task automatic test_arbitration();
        logic [11:0] a; logic [31:0] d, old; bit g[$]; logic [31:0] rd[$]; int nb, cyc;
        a   = 12'($urandom_range(0, WORDS - 1) * 4);
        d   = $urandom;
        old = exp_read(a);
        @(negedge aclk);
        areset = 1'b1;
        bus.araddr = a; bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        nb = 0; cyc = 0;
        while (nb < 2 && cyc < 60) begin
            @(negedge aclk);
            cyc++;
            if (bus.arready) g.push_back(1'b1);
            if (bus.awready) g.push_back(1'b0);
            if (bus.rvalid)  rd.push_back(bus.rdata);
            if (bus.bvalid)  nb++;
        end
        @(posedge aclk); #1;
        idle_bus();
        model_write(a, d, 4'hF);
        n_checks++;
        if (nb !== 2) begin n_fail++; $display("FAIL arb_progress: got %0d write responses, required 2", nb); end
        n_checks++;
        if (g.size() < 4) begin n_fail++; $display("FAIL arb_grants: got %0d grants, required 4", g.size()); end
        for (int i = 0; i < 4 && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL arb_order grant %0d: got %s, required %s", i,
                         g[i] ? "read" : "write", (i % 2 == 0) ? "read" : "write");
            end
        end
        n_checks++;
        if (rd.size() !== 2) begin
            n_fail++; $display("FAIL arb_reads: got %0d read beats, required 2", rd.size());
        end else begin
            n_checks++;
            if (rd[0] !== old) begin n_fail++; $display("FAIL arb_read0: got %h, required %h", rd[0], old); end
            n_checks++;
            if (rd[1] !== d) begin n_fail++; $display("FAIL arb_read_after_write: got %h, required %h", rd[1], d); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [11:0] a; logic [31:0] d; int aw_w, b_w, ar_w, r_w;
        a = 12'($urandom_range(0, WORDS - 1) * 4);
        d = $urandom;
        axi_write(a, d, 4'hF, resp, aw_w, b_w);
        model_write(a, d, 4'hF);
        bus.araddr = a; bus.arvalid = 1'b1;
        wait_sig(3, ar_w);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 12'h0F0; bus.awvalid = 1'b1;
        wait_sig(4, r_w);
        bus.arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL hold_rvalid cycle %0d: got %b, required 1", i, bus.rvalid); end
            n_checks++;
            if (bus.rdata !== exp_read(a)) begin
                n_fail++; $display("FAIL hold_rdata cycle %0d: got %h, required %h", i, bus.rdata, exp_read(a));
            end
            n_checks++;
            if ({bus.arready, bus.awready} !== 2'b00) begin
                n_fail++; $display("FAIL hold_no_grant cycle %0d: got ar/aw=%b, required 00", i, {bus.arready, bus.awready});
            end
            @(negedge aclk);
        end
        bus.rready = 1'b1;
        @(posedge aclk); #1;
        idle_bus();
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] resp; logic [11:0] a; logic [31:0] old, d; int aw_w, b_w, ar_w, r_w;
        a   = 12'($urandom_range(0, WORDS - 1) * 4);
        old = $urandom;
        axi_write(a, old, 4'hF, resp, aw_w, b_w);
        model_write(a, old, 4'hF);
        bus.awaddr = a; bus.awvalid = 1'b1;
        wait_sig(0, aw_w);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wdata = ~old; bus.wstrb = 4'hF; bus.wvalid = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wdata: got wready %b, required 1", bus.wready); end
        areset = 1'b1;
        #1;
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata} !== 41'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got flags %b bresp %b rresp %b rdata %h, required all zero",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, bus.bresp, bus.rresp, bus.rdata);
        end
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_idle: got %b, required 00000",
                               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        @(posedge aclk); #1;
        axi_read(a, d, resp, ar_w, r_w);
        n_checks++;
        if (ar_w !== 1) begin n_fail++; $display("FAIL midrst_restart: got arready at N+%0d, required N+1", ar_w); end
        n_checks++;
        if (d !== exp_read(a)) begin n_fail++; $display("FAIL midrst_mem_kept: got %h, required %h", d, exp_read(a)); end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [11:0] a; logic [31:0] d; logic [3:0] s; int aw_w, b_w, ar_w, r_w;
        for (int i = 0; i < 80; i++) begin
            a = 12'($urandom_range(0, 12'h47F));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                axi_write(a, d, s, resp, aw_w, b_w);
                model_write(a, d, s);
                n_checks++;
                if (resp !== exp_resp(a)) begin
                    n_fail++; $display("FAIL rand_bresp addr %h: got %b, required %b", a, resp, exp_resp(a));
                end
            end else begin
                axi_read(a, d, resp, ar_w, r_w);
                n_checks++;
                if (resp !== exp_resp(a)) begin
                    n_fail++; $display("FAIL rand_rresp addr %h: got %b, required %b", a, resp, exp_resp(a));
                end
                n_checks++;
                if (d !== exp_read(a)) begin
                    n_fail++; $display("FAIL rand_rdata addr %h: got %h, required %h", a, d, exp_read(a));
                end
                n_checks++;
                if (ar_w + 1 + r_w !== 2) begin
                    n_fail++; $display("FAIL rand_rvalid_latency addr %h: got N+%0d, required N+2", a, ar_w + 1 + r_w);
                end
            end
        end
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_fill();
        test_write_read();
        test_strobe();
        test_out_of_range();
        test_w_before_aw();
        test_arbitration();
        test_backpressure();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
